// File: rtl/probe_pkg.sv
// Shared constants and types for the probe uplink hub: command encodings,
// packet header field positions, hub FSM states and the FIFO word layout.
package probe_pkg;

    localparam int         PROBE_CMD_W = 19;
    localparam logic [2:0] PENABLE     = 3'd2;
    localparam logic [2:0] PSENDONCE   = 3'd5;

    // Header word layout: {id[15:0], 8'b0, data_word_count[7:0]}
    localparam int HDR_ID_MSB = 31;
    localparam int HDR_ID_LSB = 16;
    localparam int HDR_W_MSB  = 7;
    localparam int HDR_W_LSB  = 0;

    typedef enum logic {
        IDLE,
        XFER
    } hub_state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } fifo_word_t;

    function automatic logic [7:0] hdr_words(input logic [31:0] hdr);
        return hdr[HDR_W_MSB:HDR_W_LSB];
    endfunction

endpackage

// File: rtl/probe_word_fifo.sv
// Word FIFO between the uplink arbiter and the serial transport.
// Power-of-two depth; pushes are ignored when full, pops when empty.
module probe_word_fifo #(
    parameter int Width = 33,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic [AddrW-1:0] r_wr_ptr;
    logic [AddrW-1:0] r_rd_ptr;
    logic [AddrW:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AddrW + 1)'(Depth));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: storage is not reset; only pointers and count need a known state,
    // and leaving the array out of reset lets it map onto plain RAM cells.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AddrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AddrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AddrW + 1)'(1);
                2'b01:   r_count <= r_count - (AddrW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/probe_uplink_hub.sv
// Host-side probe link hub: broadcasts host commands downstream and drains
// whole probe packets, round-robin, into a word FIFO feeding the transport.
module probe_uplink_hub
    import probe_pkg::*;
#(
    parameter int NumProbes = 4,
    parameter int FifoDepth = 4
) (
    input  logic                      UCLK,
    input  logic                      URST,
    input  logic                      HCMD_VALID,
    input  logic [PROBE_CMD_W-1:0]    HCMD,
    output logic                      CMDEN,
    output logic [PROBE_CMD_W-1:0]    CMD,
    input  logic [32*NumProbes-1:0]   DATAUP,
    input  logic [NumProbes-1:0]      DATAVALID,
    input  logic [NumProbes-1:0]      DELAY,
    output logic [NumProbes-1:0]      ACK,
    output logic [31:0]               OUT_DATA,
    output logic                      OUT_VALID,
    output logic                      OUT_LAST,
    input  logic                      OUT_READY,
    output logic                      PENDING,
    output logic                      ERR
);

    localparam int SelW = (NumProbes > 1) ? $clog2(NumProbes) : 1;

    hub_state_t       r_state;
    hub_state_t       w_next_state;
    logic [SelW-1:0]  r_sel;
    logic [SelW-1:0]  r_rr;
    logic             r_first;
    logic [7:0]       r_cnt;
    logic             r_err;
    logic             r_pending;
    logic             r_cmden;
    logic [PROBE_CMD_W-1:0] r_cmd;

    logic [31:0]      w_words [NumProbes];
    logic [31:0]      w_word;
    logic [SelW-1:0]  w_cand;
    logic [SelW-1:0]  w_grant_sel;
    logic             w_grant_valid;
    logic             w_ack;
    logic             w_drop;
    logic             w_last;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    fifo_word_t       w_push_word;
    fifo_word_t       w_head;

    for (genvar gi = 0; gi < NumProbes; gi++) begin : g_words
        assign w_words[gi] = DATAUP[32*gi +: 32];
    end

    assign w_word = w_words[r_sel];
    assign w_ack  = (r_state == XFER) && DATAVALID[r_sel] && !w_fifo_full;
    assign w_drop = (r_state == XFER) && !DATAVALID[r_sel];
    assign w_last = r_first ? (hdr_words(w_word) == 8'd0) : (r_cnt == 8'd1);

    // Round-robin search starts one past the last served probe.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_sel   = '0;
        w_cand        = '0;
        for (int k = 1; k <= NumProbes; k++) begin
            w_cand = SelW'((int'(r_rr) + k) % NumProbes);
            if (!w_grant_valid && DATAVALID[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        ACK          = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = XFER;
                end
            end
            XFER: begin
                if (w_ack) begin
                    ACK[r_sel] = 1'b1;
                end
                if (w_drop || (w_ack && w_last)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge UCLK or posedge URST) begin
        if (URST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge UCLK or posedge URST) begin
        if (URST) begin
            r_sel   <= '0;
            r_rr    <= '0;
            r_first <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_grant_valid) begin
                r_sel   <= w_grant_sel;
                r_first <= 1'b1;
            end
            if (w_ack) begin
                r_first <= 1'b0;
                r_cnt   <= r_first ? hdr_words(w_word) : r_cnt - 8'd1;
                if (w_last) begin
                    r_rr <= r_sel;
                end
            end
            // A probe vanishing mid-packet abandons it; words already queued stay.
            if (w_drop) begin
                r_err <= 1'b1;
                r_rr  <= r_sel;
            end
        end
    end

    always_ff @(posedge UCLK or posedge URST) begin
        if (URST) begin
            r_cmden   <= 1'b0;
            r_cmd     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cmden   <= HCMD_VALID;
            r_pending <= |DELAY;
            if (HCMD_VALID) begin
                r_cmd <= HCMD;
            end
        end
    end

    assign w_push_word = '{last: w_last, data: w_word};

    probe_word_fifo #(
        .Width ($bits(fifo_word_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .i_clk   (UCLK),
        .i_rst   (URST),
        .i_push  (w_ack),
        .i_data  (w_push_word),
        .i_pop   (OUT_READY),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign OUT_DATA  = w_head.data;
    assign OUT_VALID = !w_fifo_empty;
    assign OUT_LAST  = w_head.last && !w_fifo_empty;
    assign CMDEN     = r_cmden;
    assign CMD       = r_cmd;
    assign PENDING   = r_pending;
    assign ERR       = r_err;

endmodule

// File: tb/tb_probe_uplink_hub.sv
// Self-checking bench for probe_uplink_hub: behavioural probes feed packets,
// a round-robin packet-order model predicts the output word stream.
module tb_probe_uplink_hub;
    import probe_pkg::*;

    localparam int NP    = 4;
    localparam int DEPTH = 4;
    localparam int MEMW  = 2048;

    logic                   UCLK = 1'b0;
    logic                   URST = 1'b0;
    logic                   HCMD_VALID = 1'b0;
    logic [PROBE_CMD_W-1:0] HCMD = '0;
    logic                   CMDEN;
    logic [PROBE_CMD_W-1:0] CMD;
    logic [32*NP-1:0]       DATAUP = '0;
    logic [NP-1:0]          DATAVALID = '0;
    logic [NP-1:0]          DELAY = '0;
    logic [NP-1:0]          ACK;
    logic [31:0]            OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_LAST;
    logic                   OUT_READY = 1'b0;
    logic                   PENDING;
    logic                   ERR;

    always #5 UCLK = ~UCLK;

    probe_uplink_hub #(
        .NumProbes (NP),
        .FifoDepth (DEPTH)
    ) dut (
        .UCLK       (UCLK),
        .URST       (URST),
        .HCMD_VALID (HCMD_VALID),
        .HCMD       (HCMD),
        .CMDEN      (CMDEN),
        .CMD        (CMD),
        .DATAUP     (DATAUP),
        .DATAVALID  (DATAVALID),
        .DELAY      (DELAY),
        .ACK        (ACK),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_LAST   (OUT_LAST),
        .OUT_READY  (OUT_READY),
        .PENDING    (PENDING),
        .ERR        (ERR)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Probe word streams and the expected output stream {last, data}
    logic [31:0] pmem [NP][MEMW];
    int          phead [NP];
    int          ptail [NP];
    int          ack_cnt [NP];
    logic [32:0] exp_q [$];
    int          n_extra = 0;
    bit          auto_ready = 1'b0;
    bit          chk_pending = 1'b0;

    // Packets loaded since the last prediction, and the model's round-robin pointer
    int bt_cnt [NP];
    int bt_start [NP][8];
    int bt_w [NP][8];
    int m_rr = 0;

    task automatic drive_probes();
        for (int i = 0; i < NP; i++) begin
            DATAVALID[i]      = (phead[i] < ptail[i]);
            DATAUP[32*i +: 32] = DATAVALID[i] ? pmem[i][phead[i]] : 32'h0;
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NP; i++) begin
            if (phead[i] < ptail[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        logic [NP-1:0] ack_seen;
        logic [32:0]   e;
        @(negedge UCLK);
        ack_seen = ACK;
        if (ACK != '0) begin
            check("ack_onehot", 64'($onehot(ACK)), 1);
            check("ack_on_valid", ACK & ~DATAVALID, 0);
        end
        for (int i = 0; i < NP; i++) begin
            if (ack_seen[i]) ack_cnt[i]++;
        end
        if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                n_extra++;
            end else begin
                e = exp_q.pop_front();
                check("out_data", OUT_DATA, e[31:0]);
                check("out_last", OUT_LAST, e[32]);
            end
        end
        @(posedge UCLK);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (ack_seen[i]) phead[i]++;
        end
        drive_probes();
        if (chk_pending) begin
            check("pending", PENDING, |DELAY);
            DELAY = NP'($urandom);
        end
        if (auto_ready) OUT_READY = 1'($urandom_range(0, 1));
    endtask

    task automatic add_pkt(input int p, input logic [15:0] id, input int w);
        if (phead[p] == ptail[p]) begin
            phead[p] = 0;
            ptail[p] = 0;
        end
        bt_start[p][bt_cnt[p]] = ptail[p];
        bt_w[p][bt_cnt[p]]     = w;
        bt_cnt[p]++;
        pmem[p][ptail[p]] = {id, 8'h00, 8'(w)};
        ptail[p]++;
        for (int j = 0; j < w; j++) begin
            pmem[p][ptail[p]] = $urandom;
            ptail[p]++;
        end
    endtask

    // All probes of a batch present together, so packet order follows purely
    // from round-robin over probes that still have packets.
    task automatic predict_batch();
        int k [NP];
        int pick;
        int p;
        int s;
        for (int i = 0; i < NP; i++) k[i] = 0;
        for (int guard = 0; guard < 64; guard++) begin
            pick = -1;
            for (int j = 1; j <= NP; j++) begin
                p = (m_rr + j) % NP;
                if (pick < 0 && k[p] < bt_cnt[p]) pick = p;
            end
            if (pick < 0) break;
            s = bt_start[pick][k[pick]];
            for (int q = 0; q <= bt_w[pick][k[pick]]; q++) begin
                exp_q.push_back({(q == bt_w[pick][k[pick]]), pmem[pick][s + q]});
            end
            k[pick]++;
            m_rr = pick;
        end
        for (int i = 0; i < NP; i++) bt_cnt[i] = 0;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy()) && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        int n;
        for (int i = 0; i < NP; i++) begin
            phead[i] = 0; ptail[i] = 0; ack_cnt[i] = 0; bt_cnt[i] = 0;
        end

        // Reset state
        #2 URST = 1'b1;
        #1;
        check("rst_ack", ACK, 0);
        check("rst_out_valid", OUT_VALID, 0);
        tick(); tick();
        check("rst_cmden", CMDEN, 0);
        check("rst_cmd", CMD, 0);
        check("rst_out_last", OUT_LAST, 0);
        check("rst_pending", PENDING, 0);
        check("rst_err", ERR, 0);
        URST = 1'b0;
        tick();

        // Downlink commands
        HCMD_VALID = 1'b1;
        HCMD = {16'd2, PSENDONCE};
        tick();
        check("cmd_en", CMDEN, 1);
        check("cmd_val", CMD, 19'h00015);
        HCMD_VALID = 1'b0;
        HCMD = {16'h7777, PENABLE};
        tick();
        check("cmd_en_off", CMDEN, 0);
        check("cmd_hold", CMD, 19'h00015);
        HCMD_VALID = 1'b1;
        HCMD = {16'd9, PENABLE};
        tick();
        check("cmd_b2b0", CMD, {16'd9, PENABLE});
        HCMD = {16'd3, PSENDONCE};
        tick();
        check("cmd_b2b1_en", CMDEN, 1);
        check("cmd_b2b1", CMD, {16'd3, PSENDONCE});
        HCMD_VALID = 1'b0;
        tick();

        // Single probe, one data word
        OUT_READY = 1'b1;
        a0 = ack_cnt[0];
        add_pkt(0, 16'h0003, 1);
        pmem[0][bt_start[0][0] + 1] = 32'hDEADBEEF;
        predict_batch();
        drive_probes();
        drain("t1", 50);
        check("t1_acks", ack_cnt[0] - a0, 2);

        // Back-pressure: FIFO fills and ACK stalls until popping resumes
        OUT_READY = 1'b0;
        a0 = ack_cnt[0];
        add_pkt(0, 16'h0010, 5);
        predict_batch();
        drive_probes();
        for (int i = 0; i < 12; i++) tick();
        check("t2_acks_stalled", ack_cnt[0] - a0, DEPTH);
        check("t2_out_valid", OUT_VALID, 1);
        check("t2_head_not_last", OUT_LAST, 0);
        OUT_READY = 1'b1;
        drain("t2", 100);
        check("t2_acks_total", ack_cnt[0] - a0, 6);

        // Two probes contending, then again with a different pointer
        add_pkt(1, 16'h0101, 2);
        add_pkt(2, 16'h0202, 3);
        predict_batch();
        drive_probes();
        drain("t3a", 100);
        add_pkt(1, 16'h0111, 0);
        predict_batch();
        drive_probes();
        drain("t3b", 50);
        add_pkt(1, 16'h0121, 1);
        add_pkt(2, 16'h0222, 1);
        predict_batch();
        drive_probes();
        drain("t3c", 100);

        // Granted probe drops its data after the header
        a0 = ack_cnt[0];
        phead[0] = 0;
        ptail[0] = 0;
        pmem[0][0] = {16'h00E5, 8'h00, 8'd2};
        pmem[0][1] = $urandom;
        pmem[0][2] = $urandom;
        ptail[0] = 3;
        exp_q.push_back({1'b0, pmem[0][0]});
        drive_probes();
        n = 0;
        while (ack_cnt[0] == a0 && n < 50) begin
            tick();
            n++;
        end
        check("t5_hdr_acked", ack_cnt[0] - a0, 1);
        ptail[0] = phead[0];
        drive_probes();
        tick(); tick(); tick();
        check("t5_err", ERR, 1);
        check("t5_ack_idle", ACK, 0);
        m_rr = 0;
        drain("t5", 50);
        add_pkt(1, 16'h0E01, 2);
        predict_batch();
        drive_probes();
        drain("t5_after", 100);
        check("t5_err_hold", ERR, 1);

        // Randomized batches with random back-pressure and DELAY
        auto_ready = 1'b1;
        chk_pending = 1'b1;
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < NP; p++) begin
                int np;
                np = $urandom_range(0, 2);
                if (p == b % NP && np == 0) np = 1;
                for (int k = 0; k < np; k++) begin
                    add_pkt(p, 16'($urandom), (b == 3 && p == 3 && k == 0) ? 255 : int'($urandom_range(0, 4)));
                end
            end
            predict_batch();
            drive_probes();
            drain("rand", 3000);
        end
        auto_ready = 1'b0;
        chk_pending = 1'b0;
        DELAY = '0;

        // Reset in the middle of a packet
        OUT_READY = 1'b0;
        add_pkt(2, 16'h0BAD, 6);
        predict_batch();
        drive_probes();
        HCMD_VALID = 1'b1;
        HCMD = {16'd1, PENABLE};
        a0 = ack_cnt[2];
        tick(); tick(); tick();
        check("t6_active", (ack_cnt[2] - a0) > 0, 1);
        #2 URST = 1'b1;
        #1;
        check("t6_ack", ACK, 0);
        check("t6_out_valid", OUT_VALID, 0);
        check("t6_cmden", CMDEN, 0);
        check("t6_err", ERR, 0);
        exp_q.delete();
        for (int i = 0; i < NP; i++) begin
            phead[i] = 0; ptail[i] = 0; bt_cnt[i] = 0;
        end
        m_rr = 0;
        HCMD_VALID = 1'b0;
        drive_probes();
        tick(); tick();
        URST = 1'b0;
        tick();
        OUT_READY = 1'b1;
        add_pkt(1, 16'h0F00, 2);
        predict_batch();
        drive_probes();
        drain("t6_fresh", 100);
        check("t6_err_clean", ERR, 0);

        check("extra_words", n_extra, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
